// File: rtl/x25519_ladder_sequencer.sv
// x25519_ladder_sequencer: Montgomery-ladder round sequencer driving an external iteration core
module x25519_ladder_sequencer #(
  parameter int COORD_WIDTH    = 256,
  parameter int SCALAR_BITS    = 255,
  parameter int CLAMP          = 1,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int ROUND_W        = $clog2(SCALAR_BITS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     abort,
  input  logic [COORD_WIDTH-1:0]   base_x,
  input  logic [SCALAR_BITS-1:0]   scalar,
  output logic                     busy,
  output logic [ROUND_W-1:0]       round,
  output logic                     out_valid,
  output logic [2*COORD_WIDTH-1:0] result,
  output logic                     error,
  output logic                     iter_en,
  output logic                     iter_b,
  output logic [2*COORD_WIDTH-1:0] iter_xzm,
  output logic [2*COORD_WIDTH-1:0] iter_xzm1,
  input  logic                     iter_valid,
  input  logic [2*COORD_WIDTH-1:0] iter_xzm_out,
  input  logic [2*COORD_WIDTH-1:0] iter_xzm1_out
);
  localparam int XW   = 2 * COORD_WIDTH;
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [ROUND_W-1:0]     LAST   = ROUND_W'(SCALAR_BITS - 1);
  localparam logic [WD_W-1:0]        WD_MAX = WD_W'(TIMEOUT_CYCLES);
  localparam logic [SCALAR_BITS-1:0] CLR    = ~SCALAR_BITS'(7);
  localparam logic [SCALAR_BITS-1:0] SET    = SCALAR_BITS'(1) << (SCALAR_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t                 state_q, state_d;
  logic [SCALAR_BITS-1:0] scalar_q, scalar_d, scalar_c;
  logic [XW-1:0]          xzm_q, xzm_d, xzm1_q, xzm1_d, result_q, result_d;
  logic [ROUND_W-1:0]     round_q, round_d;
  logic [WD_W-1:0]        wd_q, wd_d;
  logic                   busy_q, busy_d, out_valid_q, out_valid_d, error_q, error_d;
  logic                   iter_en_q, iter_en_d, iter_b_q, iter_b_d, zero;

  assign scalar_c  = CLAMP != 0 ? (scalar & CLR) | SET : scalar;
  assign busy      = busy_q;
  assign round     = round_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign error     = error_q;
  assign iter_en   = iter_en_q;
  assign iter_b    = iter_b_q;
  assign iter_xzm  = xzm_q;
  assign iter_xzm1 = xzm1_q;

  // next-state and output decode; abort and zeroisation override everything except result
  always_comb begin
    state_d     = state_q;
    scalar_d    = scalar_q;
    xzm_d       = xzm_q;
    xzm1_d      = xzm1_q;
    result_d    = result_q;
    round_d     = round_q;
    wd_d        = wd_q;
    iter_b_d    = iter_b_q;
    iter_en_d   = 1'b0;
    out_valid_d = 1'b0;
    error_d     = 1'b0;
    zero        = 1'b0;
    if (abort) begin
      state_d = IDLE;
      zero    = 1'b1;
    end else begin
      case (state_q)
        IDLE: if (en) begin
          scalar_d  = scalar_c;
          xzm1_d    = {COORD_WIDTH'(1), base_x};
          xzm_d     = {COORD_WIDTH'(0), COORD_WIDTH'(1)};
          round_d   = LAST;
          iter_b_d  = scalar_c[SCALAR_BITS-1];
          iter_en_d = 1'b1;
          wd_d      = '0;
          state_d   = WAIT;
        end
        START: begin
          iter_b_d  = scalar_q[round_q];
          iter_en_d = 1'b1;
          wd_d      = '0;
          state_d   = WAIT;
        end
        WAIT: if (iter_valid) begin
          xzm_d   = iter_xzm_out;
          xzm1_d  = iter_xzm1_out;
          round_d = round_q == '0 ? round_q : round_q - 1'b1;
          state_d = round_q == '0 ? DONE : START;
        end else begin
          wd_d = wd_q + 1'b1;
          if (TIMEOUT_CYCLES != 0 && wd_d == WD_MAX) begin
            error_d = 1'b1;
            zero    = 1'b1;
            state_d = IDLE;
          end
        end
        DONE: begin
          result_d    = xzm_q;
          out_valid_d = 1'b1;
          zero        = 1'b1;
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    if (zero) begin
      xzm_d    = '0;
      xzm1_d   = '0;
      scalar_d = '0;
      iter_b_d = 1'b0;
      round_d  = '0;
      wd_d     = '0;
    end
    busy_d = state_d != IDLE;
  end

  // state and output registers, all cleared by the asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      scalar_q    <= '0;
      xzm_q       <= '0;
      xzm1_q      <= '0;
      result_q    <= '0;
      round_q     <= '0;
      wd_q        <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      error_q     <= 1'b0;
      iter_en_q   <= 1'b0;
      iter_b_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      scalar_q    <= scalar_d;
      xzm_q       <= xzm_d;
      xzm1_q      <= xzm1_d;
      result_q    <= result_d;
      round_q     <= round_d;
      wd_q        <= wd_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      error_q     <= error_d;
      iter_en_q   <= iter_en_d;
      iter_b_q    <= iter_b_d;
    end
  end
endmodule

// File: tb/tb_x25519_ladder_sequencer.sv
// tb_x25519_ladder_sequencer: randomized self-checking bench with a mock iteration core and a timeline model
module tb_x25519_ladder_sequencer;
  localparam int CW = 16, N = 8, TO = 16, RW = 3, XW = 2 * CW;

  logic clk = 0, rst_n = 0, en = 0, abort = 0;
  logic [CW-1:0] base_x = 0;
  logic [N-1:0] scalar = 0;
  logic busy, out_valid, error, iter_en, iter_b, iter_valid;
  logic [RW-1:0] round;
  logic [XW-1:0] result, iter_xzm, iter_xzm1, iter_xzm_out, iter_xzm1_out;

  x25519_ladder_sequencer #(.COORD_WIDTH(CW), .SCALAR_BITS(N), .CLAMP(1), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .abort(abort), .base_x(base_x), .scalar(scalar),
    .busy(busy), .round(round), .out_valid(out_valid), .result(result), .error(error),
    .iter_en(iter_en), .iter_b(iter_b), .iter_xzm(iter_xzm), .iter_xzm1(iter_xzm1),
    .iter_valid(iter_valid), .iter_xzm_out(iter_xzm_out), .iter_xzm1_out(iter_xzm1_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int checks = 0, errors = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // mock core: after lat cycles returns xzm' = 2*xzm + b, xzm1' = xzm1 + 2
  logic core_v = 0, stray_v = 0, c_b = 0, pend = 0, mute = 0;
  logic [XW-1:0] c_xzm = 0, c_xzm1 = 0, o_xzm = 0, o_xzm1 = 0;
  int cnt = 0, lat = 1;
  assign iter_valid    = core_v | stray_v;
  assign iter_xzm_out  = o_xzm;
  assign iter_xzm1_out = o_xzm1;
  always @(posedge clk) begin
    core_v <= 0;
    if (iter_en && !mute) begin
      if (lat == 1) begin
        core_v <= 1;
        o_xzm  <= (iter_xzm << 1) + XW'(iter_b);
        o_xzm1 <= iter_xzm1 + 2;
      end else begin
        pend <= 1; cnt <= lat - 2; c_xzm <= iter_xzm; c_xzm1 <= iter_xzm1; c_b <= iter_b;
      end
    end else if (pend) begin
      if (cnt == 0) begin
        core_v <= 1; pend <= 0;
        o_xzm  <= (c_xzm << 1) + XW'(c_b);
        o_xzm1 <= c_xzm1 + 2;
      end else cnt <= cnt - 1;
    end
  end

  // model state for the current run
  bit run = 0;
  int t0 = 0, P = 3, abort_e = 0;
  logic [N-1:0] k = 0;
  logic [CW-1:0] base = 0;
  logic [XW-1:0] last_res = 0, fin = 0;
  bit bseq[$];
  int bc = 0;

  function automatic logic [N-1:0] clamp(input logic [N-1:0] s);
    logic [N-1:0] c = s;
    c[2:0] = 3'b000;
    c[N-1] = 1'b1;
    return c;
  endfunction

  function automatic logic [XW-1:0] xs_at(input logic [N-1:0] kk, input int r);
    logic [XW-1:0] acc = 1;
    for (int i = 0; i < r; i++) acc = acc * 2 + XW'(kk[N-1-i]);
    return acc;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic launch(input logic [N-1:0] s, input int l, input bit m);
    tick;
    en = 1; scalar = s; base_x = CW'($urandom); lat = l; mute = m;
    k = clamp(s); base = base_x; t0 = cyc + 1; P = l + 2; abort_e = 0; fin = xs_at(k, N); run = 1;
    bseq.delete(); bc = 0;
    tick;
    en = 0;
  endtask

  task automatic wait_e(input int target);
    for (int i = 0; i < 600 && (cyc - t0 + 1) < target; i++) tick;
  endtask

  task automatic wait_idle;
    for (int i = 0; i < 600 && run; i++) tick;
    chk("run_finished", 64'(run), 64'd0);
  endtask

  task automatic wait_ov(output int e);
    e = -1;
    for (int i = 0; i < 600; i++) begin
      tick;
      if (out_valid) begin
        e = cyc - t0 + 1;
        break;
      end
    end
  endtask

  function automatic logic [N-1:0] packed_bits();
    logic [N-1:0] pk = 0;
    foreach (bseq[i]) pk = {pk[N-2:0], bseq[i]};
    return pk;
  endfunction

  // collects the iter_b sequence and the number of busy cycles of a run
  always @(negedge clk) begin
    if (iter_en) bseq.push_back(iter_b);
    if (busy) bc++;
  end

  // every-cycle comparison of the DUT against the run timeline
  always @(negedge clk) begin : cmp
    int e, r, p, er, end_e;
    bit eb, een, eib, eov, eerr, act;
    logic [XW-1:0] ex, ex1;
    if (rst_n) begin
      e = cyc - t0 + 1;
      eb = 0; een = 0; er = 0; eib = 0; eov = 0; eerr = 0; act = 0; ex = 0; ex1 = 0;
      if (run && e >= 1) begin
        end_e = mute ? TO + 1 : N * P + 1;
        if (abort_e > 0 && e > abort_e) run = 0;
        else if (e >= end_e) begin
          run = 0;
          if (e == end_e && mute) eerr = 1;
          if (e == end_e && !mute) begin
            eov = 1;
            last_res = fin;
          end
        end else begin
          act = 1; eb = 1;
          r = mute ? 0 : (e - 1) / P;
          p = mute ? 1 : (e - 1) % P;
          een = mute ? (e == 1) : (p == 0);
          er = N - 1 - r - ((!mute && p == P - 1 && r < N - 1) ? 1 : 0);
          eib = k[N-1-r];
          ex = xs_at(k, r);
          ex1 = {16'd1, base} + XW'(2 * r);
        end
      end
      chk("busy", 64'(busy), 64'(eb));
      chk("iter_en", 64'(iter_en), 64'(een));
      chk("round", 64'(round), 64'(er));
      chk("iter_b", 64'(iter_b), 64'(eib));
      chk("out_valid", 64'(out_valid), 64'(eov));
      chk("error", 64'(error), 64'(eerr));
      chk("result", 64'(result), 64'(last_res));
      if (!act || een) begin
        chk("iter_xzm", 64'(iter_xzm), 64'(ex));
        chk("iter_xzm1", 64'(iter_xzm1), 64'(ex1));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int e, l, ae;
    logic [N-1:0] s;
    #3;
    chk("reset_outputs", 64'({busy, round, out_valid, error, iter_en, iter_b}), 64'd0);
    chk("reset_result", 64'(result), 64'd0);
    chk("reset_ops", {iter_xzm, iter_xzm1}, 64'd0);
    tick;
    rst_n = 1;
    repeat (2) tick;

    launch(8'h07, 3, 0);
    wait_ov(e);
    chk("ov_cycle_07", 64'(e), 64'd41);
    chk("result_07", 64'(result), 64'h180);
    chk("bits_07", 64'(packed_bits()), 64'h80);
    chk("nbits_07", 64'(bseq.size()), 64'd8);
    chk("busy_cycles_07", 64'(bc), 64'd40);
    wait_idle;

    launch(8'hFF, 1, 0);
    wait_ov(e);
    chk("ov_cycle_ff", 64'(e), 64'd25);
    chk("result_ff", 64'(result), 64'h1F8);
    chk("bits_ff", 64'(packed_bits()), 64'hF8);
    chk("busy_cycles_ff", 64'(bc), 64'd24);
    wait_idle;

    launch(N'($urandom), 2, 0);
    wait_e(5 * 4 + 2);
    chk("pre_abort_round", 64'(round), 64'd2);
    abort = 1; abort_e = cyc - t0 + 1;
    tick;
    abort = 0;
    chk("abort_idle", 64'({busy, round, out_valid}), 64'd0);
    chk("abort_ops", {iter_xzm, iter_xzm1}, 64'd0);
    chk("abort_result_kept", 64'(result), 64'h1F8);
    wait_idle;
    repeat (6) tick;
    en = 1; abort = 1;
    tick;
    en = 0; abort = 0;
    chk("abort_en_no_start", 64'(busy), 64'd0);
    launch(N'($urandom), 3, 0);
    wait_idle;

    launch(N'($urandom), 2, 1);
    wait_e(TO + 1);
    chk("timeout_error", 64'({error, busy}), 64'b10);
    wait_idle;
    stray_v = 1;
    tick;
    stray_v = 0;
    repeat (3) tick;
    mute = 0;

    launch(N'($urandom), 2, 0);
    wait_e(6);
    en = 1;
    tick;
    en = 0;
    wait_e(12);
    rst_n = 0;
    #1;
    chk("async_reset_outputs", 64'({busy, round, out_valid, error, iter_en, iter_b}), 64'd0);
    chk("async_reset_result", 64'(result), 64'd0);
    chk("async_reset_ops", {iter_xzm, iter_xzm1}, 64'd0);
    run = 0; last_res = 0;
    repeat (2) tick;
    rst_n = 1;
    repeat (6) tick;
    stray_v = 1;
    tick;
    stray_v = 0;
    repeat (3) tick;

    for (int n = 0; n < 14; n++) begin
      s = N'($urandom);
      l = $urandom_range(1, 4);
      launch(s, l, 0);
      if ($urandom_range(0, 3) == 0) begin
        ae = $urandom_range(1, N * (l + 2));
        wait_e(ae);
        abort = 1; abort_e = cyc - t0 + 1;
        tick;
        abort = 0;
      end
      wait_idle;
      repeat (6) tick;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
